// File: rtl/mem_io_responder_pkg.sv
// Shared address map and byte constants for the memory/I-O responder.
package mem_io_responder_pkg;

  localparam logic [1:0]  IO_SEL          = 2'b11;
  localparam logic [17:0] IO_UART_ADDR    = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR     = 18'h30004;
  localparam logic [17:0] IO_CLK_ADDR_HI  = 18'h30007;
  localparam logic [7:0]  UART_STOP_BYTE  = 8'h00;

  // Byte idx of a 32-bit word, little-endian.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte bus plus UART rx/tx handshakes seen by the responder.
interface mem_io_responder_if;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        io_buffer_full;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        prog_stop;
  logic        tx_overflow;

  // CPU / host side
  modport master (
    output cpu_a, cpu_wr, cpu_wdata, rx_valid, rx_data, tx_ready,
    input  cpu_rdata, io_buffer_full, rx_ready, tx_valid, tx_data, prog_stop, tx_overflow
  );

  // Responder side
  modport slave (
    input  cpu_a, cpu_wr, cpu_wdata, rx_valid, rx_data, tx_ready,
    output cpu_rdata, io_buffer_full, rx_ready, tx_valid, tx_data, prog_stop, tx_overflow
  );
endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO succeeds only when a pop
// happens on the same edge, otherwise the byte is dropped and flagged.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       head,
  output logic [CNT_W-1:0] count,
  output logic             drop
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  // Head reads as zero when empty so the output is clean out of reset.
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  // Storage array, not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mem_io_responder.sv
// Responder end of the CPU byte bus: 128 KB RAM plus memory-mapped UART,
// cycle counter and program-stop. Reads return data one cycle later.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_W  = 17,
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  mem_io_responder_if.slave  bus
);
  localparam int CNT_W = $clog2(TX_DEPTH) + 1;
  localparam logic [CNT_W-1:0] HIGH_WATER = CNT_W'(TX_DEPTH - FULL_MARGIN);

  logic [17:0]           io_a;
  logic [RAM_ADDR_W-1:0] ram_a;
  logic                  is_io, uart_hit, clk_lo_hit, clk_hi_hit, rd, wr;
  logic [7:0]            ram [2**RAM_ADDR_W];
  logic [31:0]           cyc_cnt, snap;
  logic [7:0]            rd_next, rdata_p1;
  logic                  full_p1, stop_q, ovf_q;
  logic                  tx_push, tx_drop;
  logic [7:0]            tx_push_data, tx_head;
  logic [CNT_W-1:0]      tx_count;
  logic                  unused_addr_bits;

  // Only address bits 17:0 take part in decoding.
  assign unused_addr_bits = ^bus.cpu_a[31:18];

  assign io_a       = bus.cpu_a[17:0];
  assign ram_a      = bus.cpu_a[RAM_ADDR_W-1:0];
  assign wr         = bus.cpu_wr;
  assign rd         = !bus.cpu_wr;
  assign is_io      = (io_a[17:16] == IO_SEL);
  assign uart_hit   = is_io && (io_a == IO_UART_ADDR);
  assign clk_lo_hit = is_io && (io_a == IO_CLK_ADDR);
  assign clk_hi_hit = is_io && (io_a > IO_CLK_ADDR) && (io_a <= IO_CLK_ADDR_HI);

  // The rx pop strobe is combinational so it covers exactly the addressing cycle.
  assign bus.rx_ready = !rst_in && rd && uart_hit && bus.rx_valid;

  // RAM write port; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (wr && !is_io) ram[ram_a] <= bus.cpu_wdata;
  end

  // Free-running cycle counter and the snapshot taken on a low-byte read,
  // so a 4-byte read sequence sees one coherent value.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cyc_cnt <= '0;
      snap    <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (rd && clk_lo_hit) snap <= cyc_cnt;
    end
  end

  // Read data select for the byte returned next cycle.
  always_comb begin
    rd_next = 8'h00;
    if (!is_io)                          rd_next = ram[ram_a];
    else if (uart_hit && bus.rx_valid)   rd_next = bus.rx_data;
    else if (clk_lo_hit)                 rd_next = cyc_cnt[7:0];
    else if (clk_hi_hit)                 rd_next = word_byte(snap, io_a[1:0]);
  end

  // Tx push: plain UART writes filter the zero byte, the stop write forces it.
  always_comb begin
    tx_push      = 1'b0;
    tx_push_data = bus.cpu_wdata;
    if (wr && uart_hit && (bus.cpu_wdata != UART_STOP_BYTE)) begin
      tx_push = 1'b1;
    end else if (wr && clk_lo_hit) begin
      tx_push      = 1'b1;
      tx_push_data = UART_STOP_BYTE;
    end
  end

  byte_fifo #(.DEPTH(TX_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (bus.tx_ready),
    .head      (tx_head),
    .count     (tx_count),
    .drop      (tx_drop)
  );

  // ---- stage p1: registered read data, high-water flag, sticky flags ----
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rdata_p1 <= 8'h00;
      full_p1  <= 1'b0;
      stop_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rdata_p1 <= rd_next;
      full_p1  <= (tx_count >= HIGH_WATER);
      if (wr && clk_lo_hit) stop_q <= 1'b1;
      if (tx_drop)          ovf_q  <= 1'b1;
    end
  end

  assign bus.cpu_rdata      = rdata_p1;
  assign bus.io_buffer_full = full_p1;
  assign bus.prog_stop      = stop_q;
  assign bus.tx_overflow    = ovf_q;
  assign bus.tx_valid       = (tx_count != '0);
  assign bus.tx_data        = tx_head;
endmodule
